uno_hand_uart_tx: RTL and testbench

Reads the Uno game state out over UART so a host PC can log or replay a game. The game core writes the hand store and the per-player hand counts; this block reads them. On a trigger it snapshots the counts and the last card, walks the hand store through a synchronous read port, and serialises a framed byte stream on `UART_TXD`. It runs on the 1 MHz game clock, alongside the debouncers and the game core.

---
 rtl/uno_pkg.sv | 13 +
 rtl/uart_tx_byte.sv | 55 +++++
 rtl/uno_hand_uart_tx.sv | 90 +++++++++
 tb/tb_uno_hand_uart_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uno_pkg.sv
// uno_pkg: shared card type, frame constants, serialiser states and count clamp
package uno_pkg;
  typedef logic [5:0] card_t;
  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int N_PLAYERS = 4;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  function automatic logic [6:0] clamp_count(input logic [N_PLAYERS-1:0][6:0] h, input int unsigned lim);
    logic [8:0] s;
    s = '0;
    for (int i = 0; i < N_PLAYERS; i++) s = s + 9'(h[i]);
    return s > 9'(lim) ? 7'(lim) : s[6:0];
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser that accepts the next byte on the last stop cycle for gapless streams
module uart_tx_byte
  import uno_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       ready,
  output logic       stop
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  tx_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [3:0] bit_cnt;
  logic [7:0] sh;
  logic tick, accept;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign accept = load && (state == IDLE || (state == STOP && tick));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // bit sequencing: a load on the final stop cycle chains straight into the next start bit
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = load ? START : IDLE;
      START:   nxt = tick ? DATA : START;
      DATA:    nxt = tick && bit_cnt == 4'd7 ? STOP : DATA;
      STOP:    nxt = tick ? (load ? START : IDLE) : STOP;
      default: nxt = IDLE;
    endcase
  end
  // baud counter, data bit counter and shift register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
    end else begin
      cnt <= state == IDLE || tick ? '0 : cnt + 1'b1;
      bit_cnt <= state == DATA ? bit_cnt + 4'(tick) : 4'd0;
      sh <= accept ? data : state == DATA && tick ? sh >> 1 : sh;
    end
  // line level and handshake derived from the current state
  always_comb begin
    txd = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
    ready = state == STOP && tick;
    stop = state == STOP;
  end
endmodule

// File: rtl/uno_hand_uart_tx.sv
// uno_hand_uart_tx: dumps a snapshot of the Uno hand store as a framed UART byte stream (optional checksum: UNO_TX_CHECKSUM_EN)
module uno_hand_uart_tx
  import uno_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int N_CARDS = 108
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_trigger,
  input  logic [N_PLAYERS-1:0][6:0] i_hand_num,
  input  card_t                     i_last_card,
  output logic [6:0]                o_rd_addr,
  input  card_t                     i_rd_data,
  output logic                      o_txd,
  output logic                      o_busy,
  output logic                      o_done
);
  logic [N_PLAYERS-1:0][6:0] hand;
  card_t last;
  logic [6:0] count, clamp, idx, nidx, last_idx, addr;
  logic [7:0] nxt_byte, tail;
  logic busy, done, pend, start, load, ready, stop;
  assign clamp = clamp_count(i_hand_num, N_CARDS);
  assign start = i_trigger && !busy && !done;
  assign nidx = idx + 7'd1;
  assign load = start || (busy && ready && idx != last_idx);
  assign o_busy = busy;
  assign o_done = done;
  assign o_rd_addr = addr;
`ifdef UNO_TX_CHECKSUM_EN
  logic [7:0] chk;
  assign tail = chk;
  assign last_idx = 7'd6 + count;
  // running XOR of every byte after the header, sent as the closing byte
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) chk <= '0;
    else if (start) chk <= '0;
    else if (busy && ready && idx != last_idx && nidx != last_idx) chk <= chk ^ nxt_byte;
`else
  assign tail = 8'h00;
  assign last_idx = 7'd5 + count;
`endif
  // byte that follows the one on the line: last card, hand counts, cards, then the tail
  always_comb
    nxt_byte = nidx == 7'd1 ? {2'b00, last} :
               nidx < 7'd6 ? {1'b0, hand[nidx[1:0] - 2'd2]} :
               nidx < 7'd6 + count ? {2'b00, i_rd_data} : tail;
  // frame sequencer, snapshot capture and card address prefetch during each stop bit
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      idx <= '0;
      count <= '0;
      last <= '0;
      hand <= '0;
      addr <= '0;
      pend <= 1'b0;
    end else begin
      done <= busy && ready && idx == last_idx;
      if (start) begin
        busy <= 1'b1;
        idx <= '0;
        count <= clamp;
        last <= i_last_card;
        hand <= i_hand_num;
        pend <= 1'b0;
        if (clamp != 7'd0) addr <= '0;
      end else if (busy && ready) begin
        if (idx == last_idx) busy <= 1'b0;
        else begin
          idx <= nidx;
          pend <= nidx >= 7'd6 && nidx < 7'd5 + count;
        end
      end else if (stop && pend) begin
        addr <= addr + 7'd1;
        pend <= 1'b0;
      end
    end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(i_clk),
    .rst(i_rst),
    .load(load),
    .data(start ? FRAME_HDR : nxt_byte),
    .txd(o_txd),
    .ready(ready),
    .stop(stop)
  );
endmodule

// File: tb/tb_uno_hand_uart_tx.sv
// tb_uno_hand_uart_tx: frame-level model checked every cycle plus hand-computed frame contents
module tb_uno_hand_uart_tx;
  localparam int CLK = 8;
  localparam int NC = 108;
`ifdef UNO_TX_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  logic clk, rst, trigger, txd, busy, done;
  logic [3:0][6:0] hand_num;
  logic [5:0] last_card, rd_data;
  logic [6:0] rd_addr;
  logic [5:0] store [128];
  int total = 0, bad = 0, done_cnt = 0, max_addr = 0;
  logic [7:0] dec [$];
  logic [7:0] m_bytes [$];
  int m_len = 0, m_t = 0, m_cnt = 0;
  bit m_busy = 0, m_done = 0;

  uno_hand_uart_tx #(.CLKS_PER_BIT(CLK), .N_CARDS(NC)) dut (
    .i_clk(clk), .i_rst(rst), .i_trigger(trigger), .i_hand_num(hand_num),
    .i_last_card(last_card), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_txd(txd), .o_busy(busy), .o_done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= store[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_start();
    int s;
    logic [7:0] x;
    s = int'(hand_num[0]) + int'(hand_num[1]) + int'(hand_num[2]) + int'(hand_num[3]);
    m_cnt = s > NC ? NC : s;
    m_bytes.delete();
    m_bytes.push_back(8'hA5);
    m_bytes.push_back({2'b00, last_card});
    for (int i = 0; i < 4; i++) m_bytes.push_back({1'b0, hand_num[i]});
    for (int j = 0; j < m_cnt; j++) m_bytes.push_back({2'b00, store[j]});
    x = 8'h00;
    for (int i = 1; i < m_bytes.size(); i++) x ^= m_bytes[i];
    if (CK == 1) m_bytes.push_back(x);
    m_len = m_bytes.size() * 10 * CLK;
    m_t = 0;
    m_busy = 1;
  endtask

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_busy = 0;
      m_done = 0;
      m_t = 0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == m_len) begin
        m_busy = 0;
        m_done = 1;
      end
    end else begin
      if (trigger && !m_done) model_start();
      m_done = 0;
    end

  always @(negedge clk) begin
    int p, b;
    logic et;
    et = 1'b1;
    if (m_busy) begin
      b = m_t / (10 * CLK);
      p = (m_t / CLK) % 10;
      et = p == 0 ? 1'b0 : p == 9 ? 1'b1 : m_bytes[b][p-1];
    end
    check("txd", txd, et);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    if (m_busy) begin
      if (m_cnt == 0) check("rd_addr_hold", rd_addr, 0);
      else check("rd_addr_range", rd_addr < m_cnt, 1);
      if (int'(rd_addr) > max_addr) max_addr = rd_addr;
    end
    if (done === 1'b1) done_cnt++;
  end

  initial forever begin
    @(negedge clk);
    if (txd === 1'b0) begin
      logic [7:0] bv;
      repeat (CLK / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK) @(negedge clk);
        bv[i] = txd;
      end
      repeat (CLK) @(negedge clk);
      dec.push_back(bv);
    end
  end

  task automatic trig();
    trigger = 1;
    @(negedge clk);
    trigger = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", n < 20000, 1);
  endtask

  task automatic run_frame(input int h0, h1, h2, h3, input logic [5:0] lc, output int n);
    hand_num[0] = 7'(h0);
    hand_num[1] = 7'(h1);
    hand_num[2] = 7'(h2);
    hand_num[3] = 7'(h3);
    last_card = lc;
    repeat (3) @(negedge clk);
    dec.delete();
    max_addr = 0;
    trig();
    wait_done(n);
    check("byte_count", dec.size(), m_bytes.size());
    for (int i = 0; i < dec.size() && i < m_bytes.size(); i++) check("byte", dec[i], m_bytes[i]);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, dc0;
    logic [7:0] exp5 [$];
    rst = 1;
    trigger = 0;
    hand_num = '0;
    last_card = '0;
    for (int i = 0; i < 128; i++) store[i] = 6'(i % 64);
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", rd_addr, 0);
    repeat (5000) @(negedge clk);
    check("idle_no_done", done_cnt, 0);
    check("idle_txd", txd, 1);

    run_frame(0, 0, 0, 0, 6'h2A, n);
    check("zero_len", n, (6 + CK) * 10 * CLK);
    check("zero_nbytes", dec.size(), 6 + CK);
    check("zero_b1", dec[1], 8'h2A);
    check("zero_b5", dec[5], 8'h00);
    check("zero_addr", rd_addr, 0);
`ifdef UNO_TX_CHECKSUM_EN
    check("zero_chk", dec[6], 8'h2A);
`endif

    run_frame(7, 7, 7, 7, 6'h0F, n);
    check("f35_len", n, (34 + CK) * 10 * CLK);
    check("f35_nbytes", dec.size(), 34 + CK);
    check("f35_hdr", dec[0], 8'hA5);
    check("f35_last", dec[1], 8'h0F);
    check("f35_h3", dec[5], 8'h07);
    check("f35_card0", dec[6], 8'h00);
    check("f35_card27", dec[33], 8'h1B);
`ifdef UNO_TX_CHECKSUM_EN
    check("f35_chk", dec[34], 8'h0F);
`endif

    run_frame(60, 60, 0, 0, 6'h01, n);
    check("clamp_len", n, (114 + CK) * 10 * CLK);
    check("clamp_nbytes", dec.size(), 114 + CK);
    check("clamp_last_card", dec[113], 8'h2B);
    check("clamp_max_addr", max_addr, 107);

    hand_num[0] = 7'd3;
    hand_num[1] = 7'd1;
    hand_num[2] = 7'd2;
    hand_num[3] = 7'd0;
    last_card = 6'h11;
    repeat (3) @(negedge clk);
    dec.delete();
    dc0 = done_cnt;
    trig();
    repeat (300) @(negedge clk);
    trigger = 1;
    hand_num = {7'd9, 7'd9, 7'd9, 7'd9};
    last_card = 6'h3F;
    @(negedge clk);
    trigger = 0;
    wait_done(n);
    repeat (200) @(negedge clk);
    check("mid_one_done", done_cnt - dc0, 1);
    exp5 = {8'hA5, 8'h11, 8'h03, 8'h01, 8'h02, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    if (CK == 1) exp5.push_back(8'h10);
    check("mid_nbytes", dec.size(), exp5.size());
    for (int i = 0; i < exp5.size(); i++) check("mid_byte", dec[i], exp5[i]);

    hand_num = {7'd7, 7'd7, 7'd7, 7'd7};
    last_card = 6'h0F;
    repeat (3) @(negedge clk);
    trig();
    repeat (428) @(negedge clk);
    #2 rst = 1;
    #1;
    check("arst_txd", txd, 1);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_addr", rd_addr, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (200) @(negedge clk);
    run_frame(2, 0, 1, 0, 6'h05, n);
    check("post_len", n, (9 + CK) * 10 * CLK);
    check("post_nbytes", dec.size(), 9 + CK);
    check("post_last", dec[1], 8'h05);
    check("post_card2", dec[8], 8'h02);
`ifdef UNO_TX_CHECKSUM_EN
    check("post_chk", dec[9], 8'h05);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
